ibex_instr_mem_responder: RTL and testbench
===========================================

IBEX_INSTR_MEM_RESPONDER -- requirements
Module: ibex_instr_mem_responder

Interface
REQ-001 SHALL have parameter MemWords, default 256, giving memory depth in 32-bit words (power of two).
REQ-002 SHALL have parameter GntDelay, default 0, giving cycles a request is held before grant (0..7).
REQ-003 SHALL have parameter RespLatency, default 1, giving minimum cycles from grant to rvalid (1..7).
REQ-004 SHALL have parameter MaxOutstanding, default 2, giving the response queue depth (1..4).
REQ-005 SHALL have one clock and an asynchronous active-low reset: clk_i input 1 (rising edge), then rst_ni input 1.
REQ-006 instr_req_i  input  1  fetch request from the prefetch buffer.
REQ-007 instr_addr_i  input  32  fetch byte address; bits [1:0] ignored.
REQ-008 instr_gnt_o  output  1  request accepted this cycle.
REQ-009 instr_rvalid_o  output  1  response valid this cycle.
REQ-010 instr_rdata_o  output  32  response data.
REQ-011 instr_err_o  output  1  response error flag.
REQ-012 mem_we_i  input  1  bench preload write enable.
REQ-013 mem_waddr_i  input  log2(MemWords)  preload word address.
REQ-014 mem_wdata_i  input  32  preload data.
REQ-015 outstanding_o  output  3  granted-but-unanswered request count.

Function
REQ-016 Grant FSM SHALL have states IDLE, WAIT, GRANT: IDLE->WAIT on instr_req_i with GntDelay>0; WAIT->GRANT when the held-request counter reaches GntDelay; GRANT->IDLE after the grant cycle; any state->IDLE when instr_req_i drops without grant.
REQ-017 With GntDelay=0, instr_gnt_o SHALL be combinational: instr_req_i AND outstanding_o < MaxOutstanding.
REQ-018 instr_gnt_o SHALL never assert when outstanding_o == MaxOutstanding, even if a response pops the same cycle; the FSM SHALL hold in GRANT until space frees.
REQ-019 Held-request counter SHALL clear on grant and on instr_req_i low.
REQ-020 On grant SHALL push {data, err} to the in-order queue: word index = instr_addr_i[31:2]; err=1 and data=0 if index >= MemWords, else err=0 and data=mem[index].
REQ-021 Memory read at grant SHALL return pre-write contents when mem_we_i writes the same word the same cycle (read-before-write).
REQ-022 Each queue entry SHALL carry an age counter, 0 in grant cycle, incrementing each cycle and saturating at RespLatency.
REQ-023 instr_rvalid_o SHALL be a registered one-cycle pulse for the head entry once its age reaches RespLatency: grant at cycle T gives earliest rvalid at T+RespLatency.
REQ-024 At most one response per cycle; responses SHALL be strictly in grant order; head pops in its rvalid cycle.
REQ-025 instr_rdata_o and instr_err_o SHALL be 0 whenever instr_rvalid_o is 0.
REQ-026 outstanding_o SHALL increment on grant, decrement on pop, and stay unchanged on simultaneous grant and pop.
REQ-027 Queue pointers SHALL wrap modulo MaxOutstanding with no loss or duplication.
REQ-028 instr_addr_i changes while instr_req_i is high and ungranted SHALL use the address sampled in the grant cycle.

Reset
REQ-029 While rst_ni is low: instr_gnt_o=0, instr_rvalid_o=0, instr_rdata_o=0, instr_err_o=0, outstanding_o=0, FSM=IDLE, counters=0, queue empty.
REQ-030 Reset mid-operation SHALL discard all outstanding responses; no rvalid SHALL follow reset release for pre-reset grants.
REQ-031 Memory array contents SHALL NOT be cleared by reset.

Verification
REQ-032 Preload mem[4]=0x00000013, defaults; req at addr 0x10 in cycle T -> gnt in T, rvalid in T+1, rdata=0x00000013, err=0.
REQ-033 GntDelay=2; req held from T at addr 0x0 -> gnt in T+2 only, rvalid in T+3.
REQ-034 MaxOutstanding=2, RespLatency=3; req held at 0x0, 0x4, 0x8 -> gnt at T, T+1, third stalls until T+3 pop; rvalid at T+3, T+4, T+6 with data in order.
REQ-035 MemWords=256; req at addr 0x400 -> rvalid with err=1, rdata=0; next req at 0x3FC -> err=0, rdata=mem[255].
REQ-036 Two grants outstanding, rst_ni low for one cycle -> all outputs 0, outstanding_o=0, no rvalid for 10 cycles after release; preloaded data still readable.
REQ-037 mem_we_i writes 0xDEADBEEF to word 8 in grant cycle of addr 0x20 -> old data returned; next fetch of 0x20 returns 0xDEADBEEF.

Source files
------------

// File: rtl/ibex_instr_mem_responder.sv
// ibex_instr_mem_responder
//   Behavioural instruction-memory slave for the Ibex fetch port. A request is
//   granted after an optional hold delay. The granted word is read immediately
//   and queued in order with an age counter. It is returned as a one-cycle
//   registered rvalid pulse once it has aged RespLatency cycles. Words outside
//   the memory return err=1 with zero data. The array is loaded through a
//   separate write port. Reset does not clear the array.
//
// Ports
//   clk_i, rst_ni       clock (rising edge), asynchronous active-low reset
//   instr_req_i         fetch request
//   instr_addr_i        fetch byte address, bits [1:0] ignored
//   instr_gnt_o         request accepted this cycle
//   instr_rvalid_o      response valid this cycle
//   instr_rdata_o       response data, zero when no response
//   instr_err_o         response error, zero when no response
//   mem_we_i            preload write enable
//   mem_waddr_i         preload word address
//   mem_wdata_i         preload data
//   outstanding_o       granted requests not yet answered

module ibex_instr_mem_responder #(
   parameter int unsigned MemWords       = 256,
   parameter int unsigned GntDelay       = 0,
   parameter int unsigned RespLatency    = 1,
   parameter int unsigned MaxOutstanding = 2,
   localparam int unsigned AW            = $clog2(MemWords)
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   input  logic          instr_req_i,
   input  logic [31:0]   instr_addr_i,
   output logic          instr_gnt_o,
   output logic          instr_rvalid_o,
   output logic [31:0]   instr_rdata_o,
   output logic          instr_err_o,
   input  logic          mem_we_i,
   input  logic [AW-1:0] mem_waddr_i,
   input  logic [31:0]   mem_wdata_i,
   output logic [2:0]    outstanding_o
);

   // Storage is always four slots; the pointers wrap at MaxOutstanding.
   localparam int unsigned QSlots = 4;

   typedef struct packed {
      logic [31:0] data;
      logic        err;
   } resp_t;

   typedef enum logic [1:0] {IDLE, WAIT, GRANT} gnt_state_e;

   logic [31:0] mem [MemWords];

   resp_t       q_data [QSlots];
   logic [2:0]  q_age  [QSlots];
   logic [1:0]  rd_ptr, wr_ptr;
   logic [2:0]  count;

   logic        space, gnt;
   logic        pop, bypass, push, q_pop;
   resp_t       fetch, pop_data;
   logic [31:0] word_idx;

   logic        rvalid_q, err_q;
   logic [31:0] rdata_q;

   logic        unused_addr_lsb;
   assign unused_addr_lsb = ^instr_addr_i[1:0];

   function automatic logic [1:0] ptr_inc(input logic [1:0] p);
      return (p == 2'(MaxOutstanding - 1)) ? 2'd0 : p + 2'd1;
   endfunction

   // Grant is refused whenever the queue is full, even if the head leaves this
   // cycle; this keeps the grant independent of the response path.
   assign space = (count < 3'(MaxOutstanding));

   // ---------------------------------------------------------------- grant
   generate
      if (GntDelay == 0) begin : g_gnt_comb
         assign gnt = rst_ni & instr_req_i & space;
      end else begin : g_gnt_fsm
         gnt_state_e state;
         logic [2:0] held;

         // held counts the cycles the current request has been waiting.
         // With GntDelay=1 the first cycle already completes the delay.
         always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
               state <= IDLE;
               held  <= 3'd0;
            end else begin
               case (state)
                  IDLE: begin
                     if (instr_req_i) begin
                        held  <= 3'd1;
                        state <= (GntDelay == 1) ? GRANT : WAIT;
                     end else begin
                        held  <= 3'd0;
                     end
                  end
                  WAIT: begin
                     if (!instr_req_i) begin
                        state <= IDLE;
                        held  <= 3'd0;
                     end else begin
                        held <= held + 3'd1;
                        if ((held + 3'd1) == 3'(GntDelay)) state <= GRANT;
                     end
                  end
                  GRANT: begin
                     // Stays here while the queue is full.
                     if (!instr_req_i || gnt) begin
                        state <= IDLE;
                        held  <= 3'd0;
                     end
                  end
                  default: begin
                     state <= IDLE;
                     held  <= 3'd0;
                  end
               endcase
            end
         end

         assign gnt = rst_ni & instr_req_i & space & (state == GRANT);
      end
   endgenerate

   // ---------------------------------------------------------------- memory
   assign word_idx = {2'b00, instr_addr_i[31:2]};

   // Combinational read sees the old word when the preload port writes the
   // same location in the grant cycle.
   always_comb begin
      fetch = '0;
      if (word_idx >= 32'(MemWords)) fetch.err = 1'b1;
      else                           fetch.data = mem[word_idx[AW-1:0]];
   end

   always_ff @(posedge clk_i) begin
      if (mem_we_i) mem[mem_waddr_i] <= mem_wdata_i;
   end

   // ---------------------------------------------------------------- response
   // The head moves into the output register at the edge after which it will
   // be RespLatency old, so the count drops as rvalid rises. With latency 1
   // and an empty queue, a fresh grant goes straight to the output register.
   always_comb begin
      pop      = 1'b0;
      bypass   = 1'b0;
      pop_data = '0;
      if (count != 3'd0) begin
         if (q_age[rd_ptr] >= 3'(RespLatency - 1)) begin
            pop      = 1'b1;
            pop_data = q_data[rd_ptr];
         end
      end else if (gnt && (RespLatency == 1)) begin
         pop      = 1'b1;
         bypass   = 1'b1;
         pop_data = fetch;
      end
   end

   assign push  = gnt & ~bypass;
   assign q_pop = pop & ~bypass;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rd_ptr   <= 2'd0;
         wr_ptr   <= 2'd0;
         count    <= 3'd0;
         rvalid_q <= 1'b0;
         rdata_q  <= 32'd0;
         err_q    <= 1'b0;
         for (int i = 0; i < QSlots; i++) begin
            q_data[i] <= '0;
            q_age[i]  <= 3'd0;
         end
      end else begin
         for (int i = 0; i < QSlots; i++) begin
            if (q_age[i] < 3'(RespLatency)) q_age[i] <= q_age[i] + 3'd1;
         end
         // The entry is age 0 in its grant cycle, so it is stored as 1.
         if (push) begin
            q_data[wr_ptr] <= fetch;
            q_age[wr_ptr]  <= 3'd1;
            wr_ptr         <= ptr_inc(wr_ptr);
         end
         if (q_pop) rd_ptr <= ptr_inc(rd_ptr);
         // A bypassed grant is a grant and a pop together, so the count is unchanged.
         case ({push, q_pop})
            2'b10:   count <= count + 3'd1;
            2'b01:   count <= count - 3'd1;
            default: count <= count;
         endcase
         rvalid_q <= pop;
         rdata_q  <= pop ? pop_data.data : 32'd0;
         err_q    <= pop ? pop_data.err  : 1'b0;
      end
   end

   assign instr_gnt_o    = gnt;
   assign instr_rvalid_o = rvalid_q;
   assign instr_rdata_o  = rdata_q;
   assign instr_err_o    = err_q;
   assign outstanding_o  = count;

endmodule

// File: tb/tb_ibex_instr_mem_responder.sv
// Bench for ibex_instr_mem_responder. It uses three instances: defaults,
// GntDelay=2, and RespLatency=3 with MaxOutstanding=2. All three share the
// clock, the reset and the preload port. The bench runs directed steps first.
// It then runs random traffic on the third instance against a schedule model.
// In that model, a grant at cycle T answers at max(T+L, previous answer + 1).
// Inputs are driven 1 time unit after the rising edge and sampled on the
// falling edge.

module tb_ibex_instr_mem_responder;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        we = 1'b0;
   logic [7:0]  waddr = 8'd0;
   logic [31:0] wdata = 32'd0;

   logic        req_a = 1'b0, req_b = 1'b0, req_c = 1'b0;
   logic [31:0] addr_a = '0, addr_b = '0, addr_c = '0;
   logic        gnt_a, gnt_b, gnt_c, rv_a, rv_b, rv_c, er_a, er_b, er_c;
   logic [31:0] rd_a, rd_b, rd_c;
   logic [2:0]  out_a, out_b, out_c;

   int checks = 0;
   int errors = 0;

   logic [31:0] shadow [256];

   typedef struct {
      int          r;
      logic [31:0] d;
      logic        e;
   } item_t;
   item_t mq[$];

   always #5 clk = ~clk;

   ibex_instr_mem_responder u_a (
      .clk_i(clk), .rst_ni(rst_n), .instr_req_i(req_a), .instr_addr_i(addr_a),
      .instr_gnt_o(gnt_a), .instr_rvalid_o(rv_a), .instr_rdata_o(rd_a), .instr_err_o(er_a),
      .mem_we_i(we), .mem_waddr_i(waddr), .mem_wdata_i(wdata), .outstanding_o(out_a));

   ibex_instr_mem_responder #(.GntDelay(2)) u_b (
      .clk_i(clk), .rst_ni(rst_n), .instr_req_i(req_b), .instr_addr_i(addr_b),
      .instr_gnt_o(gnt_b), .instr_rvalid_o(rv_b), .instr_rdata_o(rd_b), .instr_err_o(er_b),
      .mem_we_i(we), .mem_waddr_i(waddr), .mem_wdata_i(wdata), .outstanding_o(out_b));

   ibex_instr_mem_responder #(.RespLatency(3), .MaxOutstanding(2)) u_c (
      .clk_i(clk), .rst_ni(rst_n), .instr_req_i(req_c), .instr_addr_i(addr_c),
      .instr_gnt_o(gnt_c), .instr_rvalid_o(rv_c), .instr_rdata_o(rd_c), .instr_err_o(er_c),
      .mem_we_i(we), .mem_waddr_i(waddr), .mem_wdata_i(wdata), .outstanding_o(out_c));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic drv();
      @(posedge clk);
      #1;
   endtask

   task automatic smp();
      @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   initial begin
      logic [31:0] old;
      logic [29:0] idx;
      int          t, last_r, n_out, widx;
      logic        exp_rv, exp_g;
      item_t       it;

      // Reset state, with a request present on the default instance.
      drv(); drv();
      req_a = 1'b1; addr_a = 32'h10;
      smp();
      chk("rst_gnt_a", {31'd0, gnt_a}, 0);
      chk("rst_rv_a",  {31'd0, rv_a}, 0);
      chk("rst_rd_a",  rd_a, 0);
      chk("rst_er_a",  {31'd0, er_a}, 0);
      chk("rst_out_a", {29'd0, out_a}, 0);
      chk("rst_out_c", {29'd0, out_c}, 0);
      chk("rst_gnt_b", {31'd0, gnt_b}, 0);
      drv();
      req_a = 1'b0; rst_n = 1'b1;

      // Preload every word; word 4 holds a NOP.
      for (int i = 0; i < 256; i++) begin
         we = 1'b1; waddr = 8'(i);
         wdata = (i == 4) ? 32'h0000_0013 : $urandom;
         shadow[i] = wdata;
         drv();
      end
      we = 1'b0;

      // Basic fetch with the default parameters.
      req_a = 1'b1; addr_a = 32'h10;
      smp();
      chk("a032_gnt", {31'd0, gnt_a}, 1);
      chk("a032_rv_T", {31'd0, rv_a}, 0);
      drv(); req_a = 1'b0; smp();
      chk("a032_rv", {31'd0, rv_a}, 1);
      chk("a032_rd", rd_a, 32'h0000_0013);
      chk("a032_er", {31'd0, er_a}, 0);
      chk("a032_out", {29'd0, out_a}, 0);
      drv(); smp();
      chk("a032_pulse", {31'd0, rv_a}, 0);
      chk("a032_rd0", rd_a, 0);

      // Out-of-range word, then the last word.
      drv(); req_a = 1'b1; addr_a = 32'h400; smp();
      chk("a035_gnt0", {31'd0, gnt_a}, 1);
      drv(); addr_a = 32'h3FC; smp();
      chk("a035_gnt1", {31'd0, gnt_a}, 1);
      chk("a035_rv0", {31'd0, rv_a}, 1);
      chk("a035_er0", {31'd0, er_a}, 1);
      chk("a035_rd0", rd_a, 0);
      drv(); req_a = 1'b0; smp();
      chk("a035_rv1", {31'd0, rv_a}, 1);
      chk("a035_er1", {31'd0, er_a}, 0);
      chk("a035_rd1", rd_a, shadow[255]);

      // Read-before-write on the granted word.
      drv(); req_a = 1'b1; addr_a = 32'h20;
      we = 1'b1; waddr = 8'd8; wdata = 32'hDEAD_BEEF; old = shadow[8];
      smp();
      chk("a037_gnt", {31'd0, gnt_a}, 1);
      drv(); we = 1'b0; req_a = 1'b0; shadow[8] = 32'hDEAD_BEEF; smp();
      chk("a037_rv_old", {31'd0, rv_a}, 1);
      chk("a037_rd_old", rd_a, old);
      drv(); req_a = 1'b1; addr_a = 32'h20; smp();
      chk("a037_gnt2", {31'd0, gnt_a}, 1);
      drv(); req_a = 1'b0; smp();
      chk("a037_rd_new", rd_a, 32'hDEAD_BEEF);

      // Grant delay of two cycles.
      drv(); req_b = 1'b1; addr_b = 32'h0; smp();
      chk("b033_gnt_T", {31'd0, gnt_b}, 0);
      drv(); smp();
      chk("b033_gnt_T1", {31'd0, gnt_b}, 0);
      drv(); smp();
      chk("b033_gnt_T2", {31'd0, gnt_b}, 1);
      chk("b033_rv_T2", {31'd0, rv_b}, 0);
      drv(); req_b = 1'b0; smp();
      chk("b033_rv_T3", {31'd0, rv_b}, 1);
      chk("b033_rd", rd_b, shadow[0]);
      chk("b033_gnt_T3", {31'd0, gnt_b}, 0);

      // Backpressure at two outstanding with latency 3. The address moves
      // while the third request is stalled.
      drv(); req_c = 1'b1; addr_c = 32'h0; smp();
      chk("c034_gnt_T", {31'd0, gnt_c}, 1);
      drv(); addr_c = 32'h4; smp();
      chk("c034_gnt_T1", {31'd0, gnt_c}, 1);
      chk("c034_out_T1", {29'd0, out_c}, 1);
      drv(); addr_c = 32'hC; smp();
      chk("c034_gnt_T2", {31'd0, gnt_c}, 0);
      chk("c034_out_T2", {29'd0, out_c}, 2);
      chk("c034_rv_T2", {31'd0, rv_c}, 0);
      drv(); addr_c = 32'h8; smp();
      chk("c034_gnt_T3", {31'd0, gnt_c}, 1);
      chk("c034_rv_T3", {31'd0, rv_c}, 1);
      chk("c034_rd_T3", rd_c, shadow[0]);
      chk("c034_out_T3", {29'd0, out_c}, 1);
      drv(); req_c = 1'b0; smp();
      chk("c034_rv_T4", {31'd0, rv_c}, 1);
      chk("c034_rd_T4", rd_c, shadow[1]);
      drv(); smp();
      chk("c034_rv_T5", {31'd0, rv_c}, 0);
      drv(); smp();
      chk("c034_rv_T6", {31'd0, rv_c}, 1);
      chk("c034_rd_T6", rd_c, shadow[2]);
      chk("c034_er_T6", {31'd0, er_c}, 0);
      drv(); smp();
      chk("c034_out_end", {29'd0, out_c}, 0);

      // Reset with two responses pending.
      drv(); req_c = 1'b1; addr_c = 32'h10; smp();
      chk("c036_gnt0", {31'd0, gnt_c}, 1);
      drv(); addr_c = 32'h14; smp();
      chk("c036_gnt1", {31'd0, gnt_c}, 1);
      drv(); req_c = 1'b0; rst_n = 1'b0; req_a = 1'b1; addr_a = 32'h10; smp();
      chk("c036_out", {29'd0, out_c}, 0);
      chk("c036_rv", {31'd0, rv_c}, 0);
      chk("c036_rd", rd_c, 0);
      chk("c036_er", {31'd0, er_c}, 0);
      chk("c036_gnt_a", {31'd0, gnt_a}, 0);
      drv(); rst_n = 1'b1; req_a = 1'b0;
      for (int i = 0; i < 10; i++) begin
         smp();
         chk("c036_no_rv", {31'd0, rv_c}, 0);
         drv();
      end
      req_a = 1'b1; addr_a = 32'h10; smp();
      chk("c036_gnt_post", {31'd0, gnt_a}, 1);
      drv(); req_a = 1'b0; smp();
      chk("c036_rd_post", rd_a, 32'h0000_0013);

      // Random traffic on the latency-3 instance against the schedule model.
      drv();
      t = 0; last_r = -100;
      for (int n = 0; n < 400; n++) begin
         req_c = ($urandom_range(0, 9) < 7);
         widx = $urandom_range(0, 299);
         old = $urandom;
         addr_c = {widx[29:0], old[1:0]};
         we = ($urandom_range(0, 7) == 0);
         waddr = 8'($urandom_range(0, 255));
         wdata = $urandom;
         smp();
         while (mq.size() > 0 && mq[0].r < t) void'(mq.pop_front());
         n_out = 0;
         foreach (mq[k]) if (mq[k].r > t) n_out++;
         exp_rv = 1'b0;
         if (mq.size() > 0) exp_rv = (mq[0].r == t);
         exp_g = req_c && (n_out < 2);
         chk("rnd_gnt", {31'd0, gnt_c}, {31'd0, exp_g});
         chk("rnd_out", {29'd0, out_c}, 32'(n_out));
         chk("rnd_rv", {31'd0, rv_c}, {31'd0, exp_rv});
         chk("rnd_rd", rd_c, exp_rv ? mq[0].d : 32'd0);
         chk("rnd_er", {31'd0, er_c}, {31'd0, exp_rv ? mq[0].e : 1'b0});
         if (exp_g) begin
            idx = addr_c[31:2];
            it.e = (idx >= 30'd256);
            it.d = it.e ? 32'd0 : shadow[idx[7:0]];
            it.r = (t + 3 > last_r + 1) ? t + 3 : last_r + 1;
            last_r = it.r;
            mq.push_back(it);
         end
         if (we) shadow[waddr] = wdata;
         t++;
         drv();
      end
      we = 1'b0; req_c = 1'b0;
      repeat (5) drv();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
